// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types for the bit-serial adder: the controller state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder.
// Ports:
//   i_a, i_b, i_cin : operand bits and carry-in
//   o_sum           : a ^ b ^ cin
//   o_cout          : majority(a, b, cin)
// -----------------------------------------------------------------------------
module fa_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   assign o_sum  = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : fa_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a single full-adder cell with a registered carry.
// Handshake: start is accepted only in IDLE; busy is high while bits are being
// processed; done pulses for one cycle when sum/cout become valid. sum/cout
// hold their value until the next done.
// Ports:
//   i_clk    : rising-edge clock
//   i_rst_n  : asynchronous active-low reset
//   i_start  : operation request (sampled only in IDLE)
//   i_a, i_b : WIDTH-bit operands, captured on accepted start
//   i_cin    : carry-in, captured on accepted start
//   i_sub    : subtract select (only when SERIAL_ADDER_SUB_EN is defined)
//   o_busy   : high while in RUN
//   o_done   : one-cycle result-valid pulse
//   o_sum    : registered WIDTH-bit result
//   o_cout   : registered carry-out (no-borrow flag when subtracting)
// Configuration macro: SERIAL_ADDER_SUB_EN adds the i_sub port and a - b mode.
// -----------------------------------------------------------------------------
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             r_state;
   logic [WIDTH-1:0]   r_aSh;
   logic [WIDTH-1:0]   r_bSh;
   logic [WIDTH-1:0]   r_sumSh;
   logic               r_carry;
   logic [CNT_W-1:0]   r_count;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;

   logic               w_bitSum;
   logic               w_bitCarry;
   logic [WIDTH-1:0]   w_sumNext;
   logic [WIDTH-1:0]   w_bLoad;
   logic               w_carryLoad;

   // Subtraction is a + ~b + 1: invert B and force the initial carry to one.
`ifdef SERIAL_ADDER_SUB_EN
   assign w_bLoad     = i_sub ? ~i_b : i_b;
   assign w_carryLoad = i_sub ? 1'b1 : i_cin;
`else
   assign w_bLoad     = i_b;
   assign w_carryLoad = i_cin;
`endif

   fa_cell u_faCell (
      .i_a    (r_aSh[0]),
      .i_b    (r_bSh[0]),
      .i_cin  (r_carry),
      .o_sum  (w_bitSum),
      .o_cout (w_bitCarry)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 of the
   // operands has landed in bit 0 of the result; the concat-and-shift form
   // also stays legal for WIDTH == 1.
   assign w_sumNext = WIDTH'({w_bitSum, r_sumSh} >> 1);

   // Controller, datapath shift registers and registered outputs in one
   // block so that busy/done/sum/cout change exactly with the state moves.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_aSh   <= '0;
         r_bSh   <= '0;
         r_sumSh <= '0;
         r_carry <= 1'b0;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_aSh   <= i_a;
                  r_bSh   <= w_bLoad;
                  r_carry <= w_carryLoad;
                  r_sumSh <= '0;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_aSh   <= r_aSh >> 1;
               r_bSh   <= r_bSh >> 1;
               r_carry <= w_bitCarry;
               r_sumSh <= w_sumNext;
               r_count <= r_count + 1'b1;
               if (r_count == CNT_W'(WIDTH - 1)) begin
                  r_sum   <= w_sumNext;
                  r_cout  <= w_bitCarry;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule : serial_adder
